// File: rtl/ig_frame_ctrl.sv
// Frame sequencer for the image-gradient datapath: raster-scans the image memory, feeds the
// datapath with pixel coordinates and writes each returned gradient back at its own address.
module ig_frame_ctrl #(
  parameter int unsigned W      = 256,
  parameter int unsigned H      = 256,
  parameter int unsigned AW     = 16,
  parameter int unsigned XW     = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned DP_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic          img_rd,
  output logic [AW-1:0] img_addr,
  input  logic [7:0]    img_di,
  output logic          dp_valid,
  output logic [7:0]    dp_pix,
  output logic [XW-1:0] dp_x,
  output logic [XW-1:0] dp_y,
  input  logic [19:0]   res_data,
  output logic          grad_wr,
  output logic [AW-1:0] grad_addr,
  output logic [19:0]   grad_do
);

  localparam int unsigned LW       = $clog2(W);
  localparam int unsigned Depth    = RD_LAT + DP_LAT;
  localparam int unsigned NPix     = W * H;
  localparam logic [AW-1:0] LastAddr = AW'(NPix - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     a_q, a_d;
  logic [Depth-1:0]  vld_q, vld_d;
  logic [Depth-1:0]  msk_q, msk_d;
  logic [AW-1:0]     pa_q [Depth];
  logic [AW-1:0]     pa_d [Depth];
  logic [AW-1:0]     gaddr_q, gaddr_d;
  logic [19:0]       gdo_q, gdo_d;

  logic              issue;
  logic              issue_mask;
  logic [LW-1:0]     ax;
  logic [AW-1:0]     ay;

  assign issue      = (state_q == StRead) && !hold;
  assign ax         = a_q[LW-1:0];
  assign ay         = a_q >> LW;
  assign issue_mask = (ax == LW'(W - 1)) || (ay == AW'(H - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          a_d     = '0;
        end
      end
      StRead: begin
        if (issue) begin
          a_d = a_q + 1'b1;
          if (a_q == LastAddr) state_d = StDrain;
        end
      end
      // Empty pipeline here means the final write happened in the previous cycle.
      StDrain: begin
        if (vld_q == '0) state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Each issued read (or hold bubble) walks the tracking pipeline; stage k is k+1 cycles old.
  always_comb begin
    vld_d    = {vld_q[Depth-2:0], issue};
    msk_d    = {msk_q[Depth-2:0], issue_mask};
    pa_d[0]  = a_q;
    for (int i = 1; i < Depth; i++) begin
      pa_d[i] = pa_q[i-1];
    end
    gaddr_d = gaddr_q;
    gdo_d   = gdo_q;
    if (vld_q[Depth-1]) begin
      gaddr_d = pa_q[Depth-1];
      gdo_d   = msk_q[Depth-1] ? 20'd0 : res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      vld_q   <= '0;
      msk_q   <= '0;
      gaddr_q <= '0;
      gdo_q   <= '0;
      for (int i = 0; i < Depth; i++) begin
        pa_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      vld_q   <= vld_d;
      msk_q   <= msk_d;
      gaddr_q <= gaddr_d;
      gdo_q   <= gdo_d;
      for (int i = 0; i < Depth; i++) begin
        pa_q[i] <= pa_d[i];
      end
    end
  end

  assign busy      = (state_q == StRead) || (state_q == StDrain);
  assign done      = (state_q == StFin);
  assign img_rd    = issue;
  assign img_addr  = a_q;
  assign dp_valid  = vld_q[RD_LAT-1];
  assign dp_pix    = img_di;
  assign dp_x      = XW'(pa_q[RD_LAT-1][LW-1:0]);
  assign dp_y      = XW'(pa_q[RD_LAT-1] >> LW);
  assign grad_wr   = vld_q[Depth-1];
  assign grad_addr = gaddr_d;
  assign grad_do   = gdo_d;

endmodule
